// File: rtl/sha_nonce_dispatcher_if.sv
// rtl/sha_nonce_dispatcher_if.sv - job, core and result signal bundle for the nonce dispatcher
interface sha_nonce_dispatcher_if;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_midstate;
  logic [95:0]  job_tail;
  logic [31:0]  job_nonce_lo;
  logic [31:0]  job_nonce_hi;
  logic [255:0] job_target;
  logic         abort;
  logic         core_start;
  logic [255:0] core_state;
  logic [511:0] core_msg;
  logic [255:0] core_result;
  logic         core_done;
  logic         busy;
  logic         found;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic         exhausted;

  // Dispatcher view: consumes jobs and core results, drives the core and reports results.
  modport master (
    input  job_valid, job_midstate, job_tail, job_nonce_lo, job_nonce_hi, job_target, abort,
    input  core_result, core_done,
    output job_ready, core_start, core_state, core_msg,
    output busy, found, found_nonce, found_hash, exhausted
  );

  // Environment view: job source, compression core and result sink.
  modport slave (
    output job_valid, job_midstate, job_tail, job_nonce_lo, job_nonce_hi, job_target, abort,
    output core_result, core_done,
    input  job_ready, core_start, core_state, core_msg,
    input  busy, found, found_nonce, found_hash, exhausted
  );
endinterface

// File: rtl/sha_nonce_dispatcher.sv
// rtl/sha_nonce_dispatcher.sv - double SHA-256 nonce search sequencer driving one compression core
module sha_nonce_dispatcher #(
  parameter logic [255:0] SHA_IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
  parameter int           NONCE_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  sha_nonce_dispatcher_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_P1_GO   = 3'd1,
    S_P1_ARM  = 3'd2,
    S_P1_WAIT = 3'd3,
    S_P2_GO   = 3'd4,
    S_P2_ARM  = 3'd5,
    S_P2_WAIT = 3'd6,
    S_CHECK   = 3'd7
  } state_t;

  // Cycles to wait for an abandoned core run before a new pass may start.
  localparam logic [6:0] DRAIN_LAST = 7'd69;

  state_t state, state_n;

  logic [255:0]         midstate_r;
  logic [95:0]          tail_r;
  logic [NONCE_W-1:0]   nonce_hi_r;
  logic [255:0]         target_r;
  logic [NONCE_W-1:0]   nonce_r;
  logic [255:0]         hash1_r;
  logic [255:0]         hash2_r;

  logic                 core_start_r;
  logic [255:0]         core_state_r;
  logic [511:0]         core_msg_r;
  logic                 found_r;
  logic [NONCE_W-1:0]   found_nonce_r;
  logic [255:0]         found_hash_r;
  logic                 exhausted_r;

  // Set when an abort left the core mid-run; blocks the next pass-1 start.
  logic                 drain_r;
  logic [6:0]           drain_cnt_r;

  logic                 start_go;
  logic                 hit;
  logic                 abort_now;
  logic                 core_in_flight;

  assign hit            = (hash2_r <= target_r);
  assign abort_now      = bus.abort && (state != S_IDLE);
  assign core_in_flight = (state == S_P1_ARM) || (state == S_P1_WAIT) ||
                          (state == S_P2_ARM) || (state == S_P2_WAIT);

  assign bus.job_ready   = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.core_start  = core_start_r;
  assign bus.core_state  = core_state_r;
  assign bus.core_msg    = core_msg_r;
  assign bus.found       = found_r;
  assign bus.found_nonce = found_nonce_r;
  assign bus.found_hash  = found_hash_r;
  assign bus.exhausted   = exhausted_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode; start_go marks the GO cycles that actually launch the core.
  always_comb begin
    state_n  = state;
    start_go = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.job_valid) state_n = S_P1_GO;
      end
      S_P1_GO: begin
        if (!drain_r) begin
          start_go = 1'b1;
          state_n  = S_P1_ARM;
        end
      end
      S_P1_ARM:  state_n = S_P1_WAIT;
      S_P1_WAIT: begin
        if (bus.core_done) state_n = S_P2_GO;
      end
      S_P2_GO: begin
        start_go = 1'b1;
        state_n  = S_P2_ARM;
      end
      S_P2_ARM:  state_n = S_P2_WAIT;
      S_P2_WAIT: begin
        if (bus.core_done) state_n = S_CHECK;
      end
      S_CHECK: begin
        if (nonce_r == nonce_hi_r) state_n = S_IDLE;
        else                       state_n = S_P1_GO;
      end
      default: state_n = S_IDLE;
    endcase
    if (abort_now) begin
      state_n  = S_IDLE;
      start_go = 1'b0;
    end
  end

  // Job latch, core launch registers, hash capture and result reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      midstate_r    <= '0;
      tail_r        <= '0;
      nonce_hi_r    <= '0;
      target_r      <= '0;
      nonce_r       <= '0;
      hash1_r       <= '0;
      hash2_r       <= '0;
      core_start_r  <= 1'b0;
      core_state_r  <= '0;
      core_msg_r    <= '0;
      found_r       <= 1'b0;
      found_nonce_r <= '0;
      found_hash_r  <= '0;
      exhausted_r   <= 1'b0;
    end else begin
      core_start_r <= start_go;
      found_r      <= 1'b0;
      exhausted_r  <= 1'b0;

      if (state == S_IDLE && bus.job_valid) begin
        midstate_r <= bus.job_midstate;
        tail_r     <= bus.job_tail;
        nonce_hi_r <= bus.job_nonce_hi;
        target_r   <= bus.job_target;
        nonce_r    <= bus.job_nonce_lo;
      end

      if (start_go && state == S_P1_GO) begin
        core_state_r <= midstate_r;
        core_msg_r   <= {tail_r, nonce_r, 32'h80000000, 288'h0, 64'd640};
      end

      if (start_go && state == S_P2_GO) begin
        core_state_r <= SHA_IV;
        core_msg_r   <= {hash1_r, 32'h80000000, 160'h0, 64'd256};
      end

      if (state == S_P1_WAIT && bus.core_done) hash1_r <= bus.core_result;
      if (state == S_P2_WAIT && bus.core_done) hash2_r <= bus.core_result;

      if (state == S_CHECK && !abort_now) begin
        if (hit) begin
          found_r       <= 1'b1;
          found_nonce_r <= nonce_r;
          found_hash_r  <= hash2_r;
        end
        if (nonce_r == nonce_hi_r) exhausted_r <= 1'b1;
        else                       nonce_r     <= nonce_r + 1'b1;
      end
    end
  end

  // Track an abandoned core run until it reports done or the drain window expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_r     <= 1'b0;
      drain_cnt_r <= '0;
    end else if (abort_now && core_in_flight) begin
      drain_r     <= 1'b1;
      drain_cnt_r <= '0;
    end else if (drain_r) begin
      if (bus.core_done || drain_cnt_r == DRAIN_LAST) begin
        drain_r     <= 1'b0;
        drain_cnt_r <= '0;
      end else begin
        drain_cnt_r <= drain_cnt_r + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha_nonce_dispatcher.sv
// tb/tb_sha_nonce_dispatcher.sv - directed table bench for sha_nonce_dispatcher with a mock core
module tb_sha_nonce_dispatcher;

  localparam logic [255:0] IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [95:0]  TAIL  = 96'h1122334455667788_99aabbcc;
  localparam logic [127:0] H_LOW = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [255:0] ALL1  = {256{1'b1}};
  localparam logic [255:0] T9    = {128'h0, {128{1'b1}}};
  localparam int           LAT   = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha_nonce_dispatcher_if bus();
  sha_nonce_dispatcher dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0, found_cnt = 0, exh_cnt = 0, both_cnt = 0;
  int core_err = 0;
  logic [255:0] ms_hit;

  // Mock core: result = state ^ msg_hi ^ msg_lo after LAT cycles; done held until next start.
  logic [255:0] cap_state;
  logic [511:0] cap_msg;
  logic         mbusy;
  int           mcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mbusy           <= 1'b0;
      mcnt            <= 0;
      bus.core_done   <= 1'b0;
      bus.core_result <= '0;
    end else if (bus.core_start) begin
      if (mbusy) core_err <= core_err + 1;
      cap_state     <= bus.core_state;
      cap_msg       <= bus.core_msg;
      mbusy         <= 1'b1;
      mcnt          <= LAT;
      bus.core_done <= 1'b0;
    end else if (mbusy) begin
      if (mcnt == 1) begin
        bus.core_done   <= 1'b1;
        bus.core_result <= cap_state ^ cap_msg[511:256] ^ cap_msg[255:0];
        mbusy           <= 1'b0;
        if (bus.core_state !== cap_state || bus.core_msg !== cap_msg) core_err <= core_err + 1;
      end
      mcnt <= mcnt - 1;
    end
  end

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.core_start) start_cnt++;
      if (bus.found) found_cnt++;
      if (bus.exhausted) exh_cnt++;
      if (bus.found && bus.exhausted) both_cnt++;
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    start_cnt = 0; found_cnt = 0; exh_cnt = 0; both_cnt = 0;
  endtask

  task automatic submit(input logic [31:0] lo, input logic [31:0] hi, input logic [255:0] tgt);
    @(posedge clk); #1;
    clear_counts();
    bus.job_midstate = ms_hit;
    bus.job_tail     = TAIL;
    bus.job_nonce_lo = lo;
    bus.job_nonce_hi = hi;
    bus.job_target   = tgt;
    bus.job_valid    = 1'b1;
    @(posedge clk); #1;
    bus.job_valid = 1'b0;
  endtask

  task automatic wait_exhausted(input int budget);
    for (int c = 0; c < budget && exh_cnt == 0; c++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0]  lo;
    logic [31:0]  hi;
    logic [255:0] target;
    int           starts;
    int           founds;
    int           both;
    logic [31:0]  fnonce;
    logic [255:0] fhash;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // Midstate chosen so hash2 = {96'h0, nonce ^ 9, H_LOW} through the mock core.
    ms_hit = IV ^ {TAIL, 32'h9, 32'h80000000, 96'h0} ^ 256'd640 ^
             {32'h80000000, 160'h0, 64'd256} ^ {128'h0, H_LOW};

    vecs[0] = '{32'h10, 32'h13, 256'h0, 8, 0, 0, 32'h0, 256'h0};
    vecs[1] = '{32'h5, 32'h5, ALL1, 2, 1, 1, 32'h5, {96'h0, 32'hC, H_LOW}};
    vecs[2] = '{32'h0, 32'hF, T9, 32, 1, 0, 32'h9, {96'h0, 32'h0, H_LOW}};
    vecs[3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, ALL1, 4, 2, 1, 32'hFFFFFFFF, {96'h0, 32'hFFFFFFF6, H_LOW}};
    vecs[4] = '{32'hFFFFFFFF, 32'h1, T9, 6, 0, 0, 32'hFFFFFFFF, {96'h0, 32'hFFFFFFF6, H_LOW}};
    vecs[5] = '{32'h7, 32'h9, ALL1, 6, 3, 1, 32'h9, {96'h0, 32'h0, H_LOW}};

    rst = 1'b1;
    bus.job_valid = 1'b0; bus.job_midstate = '0; bus.job_tail = '0;
    bus.job_nonce_lo = '0; bus.job_nonce_hi = '0; bus.job_target = '0; bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset job_ready", 256'(bus.job_ready), 256'd1);
    chk("reset busy", 256'(bus.busy), 256'd0);
    chk("reset core_start", 256'(bus.core_start), 256'd0);
    chk("reset found_nonce", 256'(bus.found_nonce), 256'd0);
    chk("reset found_hash", bus.found_hash, 256'd0);
    chk("reset core_state", bus.core_state, 256'd0);
    chk("reset core_msg", bus.core_msg[511:256] | bus.core_msg[255:0], 256'd0);

    for (int i = 0; i < 6; i++) begin
      submit(vecs[i].lo, vecs[i].hi, vecs[i].target);
      chk($sformatf("v%0d busy after accept", i), 256'(bus.busy), 256'd1);
      chk($sformatf("v%0d job_ready after accept", i), 256'(bus.job_ready), 256'd0);
      wait_exhausted(4000);
      chk($sformatf("v%0d core_start count", i), 256'(start_cnt), 256'(vecs[i].starts));
      chk($sformatf("v%0d found count", i), 256'(found_cnt), 256'(vecs[i].founds));
      chk($sformatf("v%0d exhausted count", i), 256'(exh_cnt), 256'd1);
      chk($sformatf("v%0d found+exhausted same cycle", i), 256'(both_cnt), 256'(vecs[i].both));
      chk($sformatf("v%0d found_nonce", i), 256'(bus.found_nonce), 256'(vecs[i].fnonce));
      chk($sformatf("v%0d found_hash", i), bus.found_hash, vecs[i].fhash);
      chk($sformatf("v%0d idle busy", i), 256'(bus.busy), 256'd0);
    end

    // Abort during pass-2 wait, then a new job must wait for the abandoned core run.
    submit(32'h0, 32'h3, ALL1);
    for (int c = 0; c < 500 && start_cnt < 2; c++) begin
      @(posedge clk); #1;
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort busy", 256'(bus.busy), 256'd0);
    chk("abort job_ready", 256'(bus.job_ready), 256'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("abort found pulses", 256'(found_cnt), 256'd0);
    chk("abort exhausted pulses", 256'(exh_cnt), 256'd0);
    submit(32'h9, 32'h9, T9);
    wait_exhausted(2000);
    chk("post-abort core_start count", 256'(start_cnt), 256'd2);
    chk("post-abort found count", 256'(found_cnt), 256'd1);
    chk("post-abort found_nonce", 256'(bus.found_nonce), 256'd9);
    chk("post-abort found_hash", bus.found_hash, {96'h0, 32'h0, H_LOW});

    // Asynchronous reset in the middle of pass-1 wait.
    submit(32'h20, 32'h40, ALL1);
    for (int c = 0; c < 500 && start_cnt < 1; c++) begin
      @(posedge clk); #1;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", 256'(bus.busy), 256'd0);
    chk("async rst job_ready", 256'(bus.job_ready), 256'd1);
    chk("async rst found_nonce", 256'(bus.found_nonce), 256'd0);
    chk("async rst found_hash", bus.found_hash, 256'd0);
    chk("async rst core_state", bus.core_state, 256'd0);
    chk("async rst core_msg", bus.core_msg[511:256] | bus.core_msg[255:0], 256'd0);
    begin
      int starts_in_rst;
      starts_in_rst = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (bus.core_start) starts_in_rst++;
      end
      chk("core_start during rst", 256'(starts_in_rst), 256'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    submit(32'h5, 32'h5, ALL1);
    wait_exhausted(2000);
    chk("after rst found_nonce", 256'(bus.found_nonce), 256'd5);
    chk("after rst found_hash", bus.found_hash, {96'h0, 32'hC, H_LOW});

    chk("core start-while-busy / operand stability errors", 256'(core_err), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
